// File: rtl/ps2_scancode_decoder_if.sv
// Key-event output channel of the PS/2 scan code decoder: head event fields plus valid/ready.
interface ps2_scancode_decoder_if;
  logic [7:0] code_o;
  logic       extended_o;
  logic       break_o;
  logic       valid_o;
  logic       ready_i;

  modport master (output code_o, extended_o, break_o, valid_o, input ready_i);
  modport slave  (input code_o, extended_o, break_o, valid_o, output ready_i);
endinterface

// File: rtl/ps2_scancode_decoder.sv
// Scan code set 2 decoder (E0/F0 prefixes, E1 Pause) feeding a key-event FIFO.
// Optional pressed-key bitmap suppressing typematic repeats: define PS2_SCANCODE_KEY_STATE_EN.
module ps2_scancode_decoder #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [7:0]             data_i,
  input  logic                   valid_i,
  output logic                   overflow_o,
  ps2_scancode_decoder_if.master ev
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, SKIP} state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } event_t;

  function automatic logic is_status(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: is_status = 1'b1;
      default:                                         is_status = 1'b0;
    endcase
  endfunction

  state_t             state_q, state_d;
  logic [2:0]         skip_q, skip_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  event_t             mem_q [FIFO_DEPTH];
  event_t             mem_d [FIFO_DEPTH];

  event_t             cand_ev_s;
  logic               cand_s, pause_s, push_s, pop_s, full_s, push_ok_s;
  event_t             head_s;

  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    cand_s    = 1'b0;
    pause_s   = 1'b0;
    cand_ev_s = '0;
    if (valid_i) begin
      case (state_q)
        IDLE: begin
          if (data_i == 8'hE0) begin
            state_d = EXT;
          end else if (data_i == 8'hF0) begin
            state_d = BRK;
          end else if (data_i == 8'hE1) begin
            state_d = SKIP;
            skip_d  = 3'd7;
          end else if (!is_status(data_i)) begin
            cand_s    = 1'b1;
            cand_ev_s = '{code: data_i, ext: 1'b0, brk: 1'b0};
          end else begin
            state_d = IDLE;
          end
        end
        EXT: begin
          if (data_i == 8'hF0) begin
            state_d = EXT_BRK;
          end else if (data_i == 8'hE0) begin
            state_d = EXT;
          end else begin
            cand_s    = 1'b1;
            cand_ev_s = '{code: data_i, ext: 1'b1, brk: 1'b0};
            state_d   = IDLE;
          end
        end
        BRK: begin
          cand_s    = 1'b1;
          cand_ev_s = '{code: data_i, ext: 1'b0, brk: 1'b1};
          state_d   = IDLE;
        end
        EXT_BRK: begin
          cand_s    = 1'b1;
          cand_ev_s = '{code: data_i, ext: 1'b1, brk: 1'b1};
          state_d   = IDLE;
        end
        SKIP: begin
          // Pause payload is ignored; the last of its 7 trailing bytes emits one event
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) begin
            cand_s    = 1'b1;
            pause_s   = 1'b1;
            cand_ev_s = '{code: 8'hE1, ext: 1'b1, brk: 1'b0};
            state_d   = IDLE;
          end else begin
            state_d = SKIP;
          end
        end
        default: state_d = IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  assign full_s = (count_q == CNT_W'(FIFO_DEPTH));

`ifdef PS2_SCANCODE_KEY_STATE_EN
  logic [511:0] key_q, key_d;
  logic [8:0]   key_idx_s;

  assign key_idx_s = {cand_ev_s.ext, cand_ev_s.code};

  always_comb begin
    key_d  = key_q;
    push_s = cand_s;
    if (cand_s && !pause_s) begin
      if (!cand_ev_s.brk) begin
        if (key_q[key_idx_s]) begin
          push_s = 1'b0;
        end else if (!full_s) begin
          key_d[key_idx_s] = 1'b1;
        end else begin
          key_d = key_q;
        end
      end else if (!full_s) begin
        key_d[key_idx_s] = 1'b0;
      end else begin
        key_d = key_q;
      end
    end else begin
      key_d = key_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      key_q <= '0;
    end else begin
      key_q <= key_d;
    end
  end
`else
  assign push_s = cand_s;
`endif

  assign pop_s     = ev.valid_o & ev.ready_i;
  assign push_ok_s = push_s & ~full_s;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    mem_d      = mem_q;
    // A push into a full FIFO is lost even when a pop frees a slot this cycle
    overflow_d = overflow_q | (push_s & full_s);
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = cand_ev_s;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      skip_q     <= 3'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      skip_q     <= skip_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  // Storage is not reset, so head fields are forced to zero while the FIFO is empty
  assign head_s        = mem_q[rd_ptr_q];
  assign ev.valid_o    = (count_q != '0);
  assign ev.code_o     = ev.valid_o ? head_s.code : 8'h00;
  assign ev.extended_o = ev.valid_o ? head_s.ext : 1'b0;
  assign ev.break_o    = ev.valid_o ? head_s.brk : 1'b0;
  assign overflow_o    = overflow_q;

endmodule
